// File: rtl/eeprom_scan_ctrl.sv
// -----------------------------------------------------------------------------
// eeprom_scan_ctrl
//
// Autonomous periodic EEPROM scanner. Every TICK_CYCLES clocks it asks the
// read_eeprom engine for an NBYTES burst at a stepping memory address inside
// [START_ADDR..END_ADDR]. When the burst ends it publishes the captured bytes
// on burst_data with a one-cycle burst_valid pulse.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   enable            scan enable; a burst in flight completes when it drops
//   eep_start         read request, held from START entry until busy is seen
//   eep_slave_addr    constant 7-bit I2C device address (SLAVE_ADDR)
//   eep_mem_addr      start address of the current/next burst
//   eep_nbytes        constant burst length (NBYTES)
//   eep_busy          read_eeprom busy
//   eep_data          read byte, valid with eep_byte_ready
//   eep_byte_ready    one-cycle strobe per received byte
//   burst_data        published burst, byte 0 in [7:0]
//   burst_addr        address of the published burst
//   burst_valid       one-cycle pulse when burst_* update
//   short_burst       with burst_valid: fewer than NBYTES bytes arrived
//   timeout_err       one-cycle pulse when a burst is abandoned
//   scan_busy         high while a burst is requested or being read
//   sweep_xor         XOR of all bytes captured since the last address wrap
//   sweep_done        one-cycle pulse on the burst that wraps the address
//
// Optional feature macro: SCAN_CHECKSUM_EN enables the sweep_xor/sweep_done
// checksum. When undefined both outputs are tied to 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module eeprom_scan_ctrl #(
  parameter int unsigned       ADDR_W         = 16,
  parameter int unsigned       NBYTES         = 2,
  parameter logic [ADDR_W-1:0] START_ADDR     = '0,
  parameter logic [ADDR_W-1:0] END_ADDR       = ADDR_W'(8),
  parameter logic [6:0]        SLAVE_ADDR     = 7'h50,
  parameter int unsigned       TICK_CYCLES    = 65536,
  parameter int unsigned       TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  eep_start,
  output logic [6:0]            eep_slave_addr,
  output logic [ADDR_W-1:0]     eep_mem_addr,
  output logic [7:0]            eep_nbytes,
  input  logic                  eep_busy,
  input  logic [7:0]            eep_data,
  input  logic                  eep_byte_ready,
  output logic [8*NBYTES-1:0]   burst_data,
  output logic [ADDR_W-1:0]     burst_addr,
  output logic                  burst_valid,
  output logic                  short_burst,
  output logic                  timeout_err,
  output logic                  scan_busy,
  output logic [7:0]            sweep_xor,
  output logic                  sweep_done
);

  localparam int unsigned TICK_W = $clog2(TICK_CYCLES);
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
  localparam int unsigned AW1    = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_READ,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [TICK_W-1:0]         tick_cnt_q;
  logic [TO_W-1:0]           to_cnt_q;
  logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [NBYTES-1:0]         fill_q, fill_d;
  logic [NBYTES-1:0][7:0]    cap_q, cap_d;
  logic [NBYTES-1:0][7:0]    burst_data_q, burst_data_d;
  logic [ADDR_W-1:0]         mem_addr_q, burst_addr_q, next_addr;
  logic [AW1-1:0]            step_sum, step_end;
  logic                      short_q, timeout_q;
  logic                      tick, in_scan, to_expire, publish, wrap;

  // Free-running tick while enabled; held at 0 otherwise so a re-enable
  // always waits a full period before the first burst.
  assign tick = enable && (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));

  assign in_scan   = (state_q == S_START) || (state_q == S_READ);
  assign to_expire = in_scan && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Burst results are latched on the READ->DONE edge so they are stable
  // during the DONE cycle when burst_valid is high.
  assign publish = (state_q == S_READ) && !eep_busy && !to_expire;

  // Wrap check is done one bit wider so a burst near the top of the address
  // space cannot alias back into range.
  assign step_sum  = {1'b0, mem_addr_q} + AW1'(NBYTES);
  assign step_end  = step_sum + AW1'(NBYTES - 1);
  assign wrap      = step_end > {1'b0, END_ADDR};
  assign next_addr = wrap ? START_ADDR : step_sum[ADDR_W-1:0];

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_WAIT_TICK;
      S_WAIT_TICK: if (!enable) state_d = S_IDLE;
                   else if (tick) state_d = S_START;
      S_START:     if (to_expire) state_d = S_WAIT_TICK;
                   else if (eep_busy) state_d = S_READ;
      S_READ:      if (to_expire) state_d = S_WAIT_TICK;
                   else if (!eep_busy) state_d = S_DONE;
      S_DONE:      state_d = enable ? S_WAIT_TICK : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Byte capture; a strobe arriving together with busy falling still counts.
  always_comb begin
    byte_cnt_d = '0;
    fill_d     = '0;
    cap_d      = cap_q;
    if (state_q == S_READ) begin
      byte_cnt_d = byte_cnt_q;
      fill_d     = fill_q;
      if (eep_byte_ready && (byte_cnt_q < CNT_W'(NBYTES))) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (byte_cnt_q == CNT_W'(i)) begin
            cap_d[i]  = eep_data;
            fill_d[i] = 1'b1;
          end
        end
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
    end
  end

  // Only slots filled by this burst overwrite the published data.
  always_comb begin
    burst_data_d = burst_data_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (fill_d[i]) burst_data_d[i] = cap_d[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      to_cnt_q     <= '0;
      byte_cnt_q   <= '0;
      fill_q       <= '0;
      mem_addr_q   <= START_ADDR;
      burst_data_q <= '0;
      burst_addr_q <= '0;
      short_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= (!enable || tick) ? '0 : tick_cnt_q + TICK_W'(1);
      to_cnt_q   <= in_scan ? to_cnt_q + TO_W'(1) : '0;
      byte_cnt_q <= byte_cnt_d;
      fill_q     <= fill_d;
      timeout_q  <= to_expire;
      if (state_q == S_DONE) mem_addr_q <= next_addr;
      if (publish) begin
        burst_data_q <= burst_data_d;
        burst_addr_q <= mem_addr_q;
        short_q      <= (byte_cnt_d < CNT_W'(NBYTES));
      end
    end
  end

  // NOTE: the capture buffer is data-only and always qualified by fill_q, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
  end

  assign eep_start      = (state_q == S_START);
  assign scan_busy      = in_scan;
  assign eep_slave_addr = SLAVE_ADDR;
  assign eep_nbytes     = 8'(NBYTES);
  assign eep_mem_addr   = mem_addr_q;
  assign burst_data     = burst_data_q;
  assign burst_addr     = burst_addr_q;
  assign burst_valid    = (state_q == S_DONE);
  assign short_burst    = (state_q == S_DONE) && short_q;
  assign timeout_err    = timeout_q;

`ifdef SCAN_CHECKSUM_EN
  logic [7:0] acc_q, burst_xor;

  always_comb begin
    burst_xor = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (fill_d[i]) burst_xor = burst_xor ^ cap_d[i];
    end
  end

  // Accumulate on publish; the wrapping DONE reports the final value and the
  // accumulator restarts on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if ((state_q == S_DONE) && wrap) begin
      acc_q <= '0;
    end else if (publish) begin
      acc_q <= acc_q ^ burst_xor;
    end
  end

  assign sweep_xor  = acc_q;
  assign sweep_done = (state_q == S_DONE) && wrap;
`else
  assign sweep_xor  = 8'h00;
  assign sweep_done = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eeprom_scan_ctrl
//
// Self-checking bench for eeprom_scan_ctrl with a small configuration
// (TICK 16, NBYTES 2, address window 4..9, timeout 32). A behavioural
// read_eeprom slave answers requests with randomized timing and data; the
// reference model predicts each published burst from the list of legal burst
// addresses, the bytes the slave handed out and the previous published data.
// Honours SCAN_CHECKSUM_EN for the sweep checksum expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_eeprom_scan_ctrl;

  localparam int ADDR_W  = 16;
  localparam int NB      = 2;
  localparam int START_A = 4;
  localparam int END_A   = 9;
  localparam int TICK    = 16;
  localparam int TMO     = 32;
  localparam int N_ADDRS = (END_A - START_A + 1) / NB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              eep_busy = 1'b0;
  logic [7:0]        eep_data = 8'h00;
  logic              eep_byte_ready = 1'b0;
  logic              eep_start;
  logic [6:0]        eep_slave_addr;
  logic [ADDR_W-1:0] eep_mem_addr;
  logic [7:0]        eep_nbytes;
  logic [8*NB-1:0]   burst_data;
  logic [ADDR_W-1:0] burst_addr;
  logic              burst_valid, short_burst, timeout_err, scan_busy;
  logic [7:0]        sweep_xor;
  logic              sweep_done;

  eeprom_scan_ctrl #(
    .ADDR_W(ADDR_W), .NBYTES(NB), .START_ADDR(16'(START_A)), .END_ADDR(16'(END_A)),
    .SLAVE_ADDR(7'h50), .TICK_CYCLES(TICK), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .eep_start(eep_start), .eep_slave_addr(eep_slave_addr), .eep_mem_addr(eep_mem_addr),
    .eep_nbytes(eep_nbytes), .eep_busy(eep_busy), .eep_data(eep_data),
    .eep_byte_ready(eep_byte_ready), .burst_data(burst_data), .burst_addr(burst_addr),
    .burst_valid(burst_valid), .short_burst(short_burst), .timeout_err(timeout_err),
    .scan_busy(scan_busy), .sweep_xor(sweep_xor), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     addr;
    logic [8*NB-1:0] data;
    bit              short_b;
    bit              sweep;
    logic [7:0]      xr;
  } exp_t;

  int              n_cmp = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              slave_mode = 0;   // 0 off, 1 full, 2 never busy, 3 one byte, 4 random length
  int              prev_start = -1;
  int              n_bursts = 0;
  int              addr_idx = 0;
  bit              tmo_expected = 0;
  bit              sweep_clr_chk = 0;
  logic [8*NB-1:0] model_data = '0;
  logic [7:0]      model_acc = 8'h00;
  logic [7:0]      data_q[$];
  exp_t            exp_q[$];
  logic [8*NB-1:0] obs_data;
  logic [15:0]     obs_addr;
  logic            obs_short, obs_sweep;
  logic [7:0]      obs_xor;

  always @(posedge clk) cyc <= cyc + 1;

  // Legal burst start addresses form a simple arithmetic list.
  function automatic logic [15:0] addr_of(input int i);
    return 16'(START_A + i * NB);
  endfunction

  function automatic void push_expected(input logic [8*NB-1:0] d, input logic [7:0] x,
                                        input bit short_b);
    exp_t e;
    model_acc = model_acc ^ x;
    e.addr    = addr_of(addr_idx);
    e.data    = d;
    e.short_b = short_b;
    e.sweep   = (addr_idx == N_ADDRS - 1);
    e.xr      = model_acc;
    if (e.sweep) model_acc = 8'h00;
`ifndef SCAN_CHECKSUM_EN
    e.sweep = 1'b0;
    e.xr    = 8'h00;
`endif
    exp_q.push_back(e);
    model_data = d;
    addr_idx   = (addr_idx + 1) % N_ADDRS;
  endfunction

  function automatic void model_reset();
    model_data    = '0;
    model_acc     = 8'h00;
    addr_idx      = 0;
    prev_start    = -1;
    n_bursts      = 0;
    sweep_clr_chk = 0;
    exp_q.delete();
    data_q.delete();
  endfunction

  // Behavioural read_eeprom: raise busy, deliver nb_send bytes, drop busy.
  task automatic serve(input int nb_send);
    logic [8*NB-1:0] d;
    logic [7:0]      b;
    logic [7:0]      x;
    bit              done;
    d = model_data;
    x = 8'h00;
    done = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    eep_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < nb_send; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (data_q.size() > 0) b = data_q.pop_front();
      else b = 8'($urandom);
      eep_data = b;
      eep_byte_ready = 1'b1;
      d[8*i +: 8] = b;
      x = x ^ b;
      if (i == nb_send - 1 && $urandom_range(0, 1) == 1) begin
        eep_busy = 1'b0;
        done = 1;
        push_expected(d, x, nb_send < NB);
      end
      @(negedge clk);
      eep_byte_ready = 1'b0;
    end
    if (!done) begin
      eep_busy = 1'b0;
      push_expected(d, x, nb_send < NB);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && eep_start === 1'b1 &&
          (slave_mode == 1 || slave_mode == 3 || slave_mode == 4)) begin
        n_cmp++;
        if (eep_mem_addr !== addr_of(addr_idx)) begin
          n_err++;
          $display("FAIL start_addr: got %0d expected %0d", eep_mem_addr, addr_of(addr_idx));
        end
        if (prev_start >= 0) begin
          n_cmp++;
          if (cyc - prev_start != TICK) begin
            n_err++;
            $display("FAIL burst_period: got %0d expected %0d", cyc - prev_start, TICK);
          end
        end
        prev_start = cyc;
        if (slave_mode == 1) serve(NB);
        else if (slave_mode == 3) serve(1);
        else serve(int'($urandom_range(1, NB)));
      end
    end
  end

  // Monitor: every published burst is checked against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sweep_clr_chk) begin
        sweep_clr_chk = 0;
        n_cmp++;
        if (sweep_xor !== 8'h00) begin
          n_err++;
          $display("FAIL sweep_clear: got %h expected 00", sweep_xor);
        end
      end
      if (timeout_err === 1'b1 && !tmo_expected) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_timeout: got 1 expected 0");
      end
      if (burst_valid === 1'b1) begin
        obs_data  = burst_data;
        obs_addr  = burst_addr;
        obs_short = short_burst;
        obs_sweep = sweep_done;
        obs_xor   = sweep_xor;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_burst: got burst at %0d expected none", burst_addr);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (burst_data !== e.data) begin
            n_err++;
            $display("FAIL burst_data: got %h expected %h", burst_data, e.data);
          end
          n_cmp++;
          if (burst_addr !== e.addr) begin
            n_err++;
            $display("FAIL burst_addr: got %0d expected %0d", burst_addr, e.addr);
          end
          n_cmp++;
          if (short_burst !== e.short_b) begin
            n_err++;
            $display("FAIL short_burst: got %b expected %b", short_burst, e.short_b);
          end
          n_cmp++;
          if (sweep_done !== e.sweep || sweep_xor !== e.xr) begin
            n_err++;
            $display("FAIL sweep: got done=%b xor=%h expected done=%b xor=%h",
                     sweep_done, sweep_xor, e.sweep, e.xr);
          end
          if (e.sweep) sweep_clr_chk = 1;
        end
        n_bursts++;
      end
    end
  end

  task automatic wait_start(input int budget, input string tag);
    int k;
    k = 0;
    while (eep_start !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (eep_start !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no eep_start expected one within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_bursts(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (n_bursts < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_bursts < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %0d bursts expected %0d", tag, n_bursts, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    eep_busy = 1'b0;
    eep_byte_ready = 1'b0;
    slave_mode = 0;
    tmo_expected = 0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int starts;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({eep_start, burst_valid, short_burst, timeout_err, scan_busy, sweep_done} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000000",
               {eep_start, burst_valid, short_burst, timeout_err, scan_busy, sweep_done});
    end
    n_cmp++;
    if (eep_mem_addr !== 16'd4 || burst_addr !== 16'd0 || burst_data !== '0 || sweep_xor !== 8'h00) begin
      n_err++;
      $display("FAIL reset_values: got mem=%0d addr=%0d data=%h xor=%h expected 4 0 0 0",
               eep_mem_addr, burst_addr, burst_data, sweep_xor);
    end
    n_cmp++;
    if (eep_slave_addr !== 7'h50 || eep_nbytes !== 8'd2) begin
      n_err++;
      $display("FAIL constants: got %h/%0d expected 50/2", eep_slave_addr, eep_nbytes);
    end
    do_reset();
    starts = 0;
    repeat (3 * TICK) begin
      @(negedge clk);
      if (eep_start === 1'b1) starts++;
    end
    n_cmp++;
    if (starts != 0) begin
      n_err++;
      $display("FAIL disabled_idle: got %0d start cycles expected 0", starts);
    end
  endtask

  task automatic test_scan();
    do_reset();
    data_q.push_back(8'hA5);
    data_q.push_back(8'h3C);
    slave_mode = 1;
    enable = 1'b1;
    wait_bursts(1, 2 * TICK + 20, "first_burst");
    n_cmp++;
    if (obs_data !== 16'h3CA5 || obs_addr !== 16'd4 || obs_short !== 1'b0) begin
      n_err++;
      $display("FAIL first_burst_fixed: got %h @%0d short=%b expected 3ca5 @4 short=0",
               obs_data, obs_addr, obs_short);
    end
    wait_bursts(5, 5 * TICK + 20, "scan_five");
  endtask

  task automatic test_timeout();
    int n;
    int b0;
    do_reset();
    slave_mode = 2;
    tmo_expected = 1;
    enable = 1'b1;
    wait_start(2 * TICK + 10, "timeout_first_start");
    n_cmp++;
    if (eep_mem_addr !== 16'd4) begin
      n_err++;
      $display("FAIL timeout_addr: got %0d expected 4", eep_mem_addr);
    end
    b0 = n_bursts;
    n = 0;
    while (eep_start === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n != TMO) begin
      n_err++;
      $display("FAIL start_high_cycles: got %0d expected %0d", n, TMO);
    end
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_pulse: got %b expected 1", timeout_err);
    end
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_width: got %b expected 0", timeout_err);
    end
    wait_start(3 * TICK + 10, "timeout_retry");
    n_cmp++;
    if (eep_mem_addr !== 16'd4 || n_bursts != b0) begin
      n_err++;
      $display("FAIL timeout_retry_addr: got %0d bursts=%0d expected 4 bursts=%0d",
               eep_mem_addr, n_bursts, b0);
    end
  endtask

  task automatic test_short();
    do_reset();
    data_q.push_back(8'h11);
    data_q.push_back(8'h22);
    slave_mode = 1;
    enable = 1'b1;
    wait_bursts(1, 2 * TICK + 20, "short_pre");
    data_q.push_back(8'h77);
    slave_mode = 3;
    wait_bursts(2, TICK + 20, "short_burst");
    n_cmp++;
    if (obs_data !== 16'h2277 || obs_addr !== 16'd6 || obs_short !== 1'b1) begin
      n_err++;
      $display("FAIL short_fixed: got %h @%0d short=%b expected 2277 @6 short=1",
               obs_data, obs_addr, obs_short);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    slave_mode = 1;
    enable = 1'b1;
    wait_bursts(1, 2 * TICK + 20, "midread_pre");
    slave_mode = 0;
    wait_start(TICK + 10, "midread_start");
    eep_busy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (scan_busy !== 1'b1 || eep_start !== 1'b0 || eep_mem_addr !== 16'd6) begin
      n_err++;
      $display("FAIL midread_enter: got busy=%b start=%b addr=%0d expected 1 0 6",
               scan_busy, eep_start, eep_mem_addr);
    end
    eep_data = 8'h99;
    eep_byte_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    eep_byte_ready = 1'b0;
    eep_busy = 1'b0;
    #1;
    n_cmp++;
    if (eep_start !== 1'b0 || burst_valid !== 1'b0 || scan_busy !== 1'b0 || eep_mem_addr !== 16'd4) begin
      n_err++;
      $display("FAIL async_reset: got start=%b valid=%b busy=%b addr=%0d expected 0 0 0 4",
               eep_start, burst_valid, scan_busy, eep_mem_addr);
    end
    @(negedge clk);
    model_reset();
    slave_mode = 1;
    rst_n = 1'b1;
    wait_bursts(1, 2 * TICK + 20, "midread_restart");
    n_cmp++;
    if (obs_addr !== 16'd4) begin
      n_err++;
      $display("FAIL restart_addr: got %0d expected 4", obs_addr);
    end
  endtask

  task automatic test_back_to_back();
    int starts;
    int k;
    do_reset();
    slave_mode = 4;
    enable = 1'b1;
    wait_bursts(9, 10 * TICK + 20, "random_bursts");
    k = 0;
    while (scan_busy !== 1'b1 && k < 2 * TICK) begin
      @(negedge clk);
      k++;
    end
    enable = 1'b0;
    wait_bursts(10, TICK + 10, "enable_drop_burst");
    starts = 0;
    repeat (3 * TICK) begin
      @(negedge clk);
      if (eep_start === 1'b1 || scan_busy === 1'b1) starts++;
    end
    n_cmp++;
    if (starts != 0) begin
      n_err++;
      $display("FAIL enable_drop_idle: got %0d active cycles expected 0", starts);
    end
  endtask

  task automatic test_sweep();
    do_reset();
    data_q.push_back(8'h01); data_q.push_back(8'h02);
    data_q.push_back(8'h04); data_q.push_back(8'h08);
    data_q.push_back(8'h10); data_q.push_back(8'h20);
    slave_mode = 1;
    enable = 1'b1;
    wait_bursts(3, 4 * TICK + 20, "sweep_bursts");
    n_cmp++;
`ifdef SCAN_CHECKSUM_EN
    if (obs_addr !== 16'd8 || obs_sweep !== 1'b1 || obs_xor !== 8'h3F) begin
      n_err++;
      $display("FAIL sweep_fixed: got @%0d done=%b xor=%h expected @8 done=1 xor=3f",
               obs_addr, obs_sweep, obs_xor);
    end
`else
    if (obs_addr !== 16'd8 || obs_sweep !== 1'b0 || obs_xor !== 8'h00) begin
      n_err++;
      $display("FAIL sweep_fixed: got @%0d done=%b xor=%h expected @8 done=0 xor=00",
               obs_addr, obs_sweep, obs_xor);
    end
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_timeout();
    test_short();
    test_reset_mid_read();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
